// File: rtl/ms_timer.sv
// ms_timer: millisecond countdown timer driven by the RTC millisecond count.
// One-shot or periodic expiry with pause, cancel, retrigger and a saturating expiry counter.
module ms_timer (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] ms_acc,
  input  logic        start,
  input  logic [31:0] dur,
  input  logic        periodic,
  input  logic        pause,
  input  logic        cancel,
  output logic        busy,
  output logic        expired,
  output logic [31:0] remaining,
  output logic [7:0]  exp_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  state_t      state_q, state_d;
  logic [31:0] prev_acc_q, dur_q, dur_d, rem_q, rem_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        per_q, per_d, exp_q, exp_d, busy_q;
  logic        tick;
  assign tick = ms_acc != prev_acc_q;
  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    per_d   = per_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    exp_d   = 1'b0;
    if (cancel) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (start) begin
      dur_d = dur;
      per_d = periodic;
      rem_d = dur;
      // a zero duration expires at once in either mode, so periodic never free-runs
      if (dur == '0) begin
        state_d = IDLE;
        exp_d   = 1'b1;
        cnt_d   = 8'd1;
      end else begin
        state_d = (state_q != IDLE && pause) ? PAUSED : RUN;
        cnt_d   = '0;
      end
    end else if (state_q == RUN) begin
      if (pause) state_d = PAUSED;
      else if (tick) begin
        if (rem_q == 32'd1) begin
          exp_d   = 1'b1;
          cnt_d   = cnt_q + {7'd0, cnt_q != 8'hff};
          rem_d   = per_q ? dur_q : '0;
          state_d = per_q ? RUN : IDLE;
        end else rem_d = rem_q - 32'd1;
      end
    end else if (state_q == PAUSED && !pause) state_d = RUN;
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      prev_acc_q <= '0;
      dur_q      <= '0;
      per_q      <= 1'b0;
      rem_q      <= '0;
      cnt_q      <= '0;
      exp_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_acc_q <= ms_acc;
      dur_q      <= dur_d;
      per_q      <= per_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      busy_q     <= state_d != IDLE;
    end
  end
  assign busy      = busy_q;
  assign expired   = exp_q;
  assign remaining = rem_q;
  assign exp_cnt   = cnt_q;
endmodule

// File: tb/tb_ms_timer.sv
// tb_ms_timer: scoreboard bench for ms_timer; expected outputs are queued with each
// stimulus cycle and compared after the following clock edge.
module tb_ms_timer;
  logic        clk = 1'b0, rstb = 1'b0;
  logic [31:0] ms_acc = '0, dur = '0;
  logic        start = 1'b0, periodic = 1'b0, pause = 1'b0, cancel = 1'b0;
  logic        busy, expired;
  logic [31:0] remaining;
  logic [7:0]  exp_cnt;
  int          tests = 0, errors = 0;
  string       phase = "reset";
  typedef struct {logic b; logic e; logic [31:0] r; logic [7:0] c;} exp_t;
  exp_t sb[$];

  ms_timer dut (
    .clk(clk), .rstb(rstb), .ms_acc(ms_acc), .start(start), .dur(dur),
    .periodic(periodic), .pause(pause), .cancel(cancel), .busy(busy),
    .expired(expired), .remaining(remaining), .exp_cnt(exp_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", phase, tag, got, want);
    end
  endtask

  task automatic check_outs(input logic eb, input logic ee, input logic [31:0] er, input logic [7:0] ec);
    check("busy", {31'd0, busy}, {31'd0, eb});
    check("expired", {31'd0, expired}, {31'd0, ee});
    check("remaining", remaining, er);
    check("exp_cnt", {24'd0, exp_cnt}, {24'd0, ec});
  endtask

  task automatic step(input logic [31:0] acc, input logic st, input logic [31:0] d,
                      input logic per, input logic pa, input logic ca,
                      input logic eb, input logic ee, input logic [31:0] er, input logic [7:0] ec);
    exp_t x;
    @(negedge clk);
    ms_acc = acc; start = st; dur = d; periodic = per; pause = pa; cancel = ca;
    sb.push_back('{eb, ee, er, ec});
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
    if (sb.size() == 0) begin
      tests++; errors++;
      $display("FAIL %s/scoreboard: got empty queue expected entry", phase);
    end else begin
      x = sb.pop_front();
      check_outs(x.b, x.e, x.r, x.c);
    end
  endtask

  task automatic tk(input logic [31:0] acc, input logic eb, input logic ee,
                    input logic [31:0] er, input logic [7:0] ec);
    step(acc, 1'b0, '0, 1'b0, 1'b0, 1'b0, eb, ee, er, ec);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check_outs(1'b0, 1'b0, '0, '0);
    @(negedge clk) rstb = 1'b1;

    phase = "oneshot";
    tk(100, 0, 0, 0, 0);
    step(100, 1, 3, 0, 0, 0, 1, 0, 3, 0);
    tk(101, 1, 0, 2, 0);
    tk(102, 1, 0, 1, 0);
    tk(103, 0, 1, 0, 1);
    tk(103, 0, 0, 0, 1);

    phase = "periodic_wrap";
    tk(32'hFFFF_FFFE, 0, 0, 0, 1);
    step(32'hFFFF_FFFE, 1, 2, 1, 0, 0, 1, 0, 2, 0);
    tk(32'hFFFF_FFFF, 1, 0, 1, 0);
    tk(0, 1, 1, 2, 1);
    tk(1, 1, 0, 1, 1);
    tk(2, 1, 1, 2, 2);
    tk(2, 1, 0, 2, 2);
    step(2, 0, 0, 0, 0, 1, 0, 0, 0, 2);

    phase = "pause";
    step(2, 1, 5, 0, 0, 0, 1, 0, 5, 0);
    tk(3, 1, 0, 4, 0);
    tk(4, 1, 0, 3, 0);
    step(4, 0, 0, 0, 1, 0, 1, 0, 3, 0);
    step(5, 0, 0, 0, 1, 0, 1, 0, 3, 0);
    step(6, 0, 0, 0, 1, 0, 1, 0, 3, 0);
    step(7, 0, 0, 0, 1, 0, 1, 0, 3, 0);
    tk(7, 1, 0, 3, 0);
    tk(8, 1, 0, 2, 0);
    tk(9, 1, 0, 1, 0);
    tk(10, 0, 1, 0, 1);

    phase = "cancel_vs_start";
    step(10, 1, 2, 0, 0, 0, 1, 0, 2, 0);
    tk(11, 1, 0, 1, 0);
    step(12, 1, 9, 0, 0, 1, 0, 0, 0, 0);
    tk(12, 0, 0, 0, 0);

    phase = "retrigger";
    step(12, 1, 3, 1, 0, 0, 1, 0, 3, 0);
    tk(13, 1, 0, 2, 0);
    tk(14, 1, 0, 1, 0);
    tk(15, 1, 1, 3, 1);
    tk(16, 1, 0, 2, 1);
    step(17, 1, 10, 0, 0, 0, 1, 0, 10, 0);
    step(17, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    phase = "zero_dur";
    step(17, 1, 0, 0, 0, 0, 0, 1, 0, 1);
    tk(17, 0, 0, 0, 1);
    step(17, 1, 0, 1, 0, 0, 0, 1, 0, 1);
    tk(18, 0, 0, 0, 1);
    tk(19, 0, 0, 0, 1);

    phase = "async_reset";
    step(19, 1, 8, 0, 0, 0, 1, 0, 8, 0);
    tk(20, 1, 0, 7, 0);
    @(negedge clk);
    #2 rstb = 1'b0;
    #1 check_outs(1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    tk(21, 0, 0, 0, 0);
    tk(22, 0, 0, 0, 0);
    step(22, 1, 2, 0, 0, 0, 1, 0, 2, 0);
    tk(23, 1, 0, 1, 0);
    tk(24, 0, 1, 0, 1);

    phase = "saturate";
    step(24, 1, 1, 1, 0, 0, 1, 0, 1, 0);
    for (int i = 1; i <= 260; i++)
      tk(24 + i, 1, 1, 1, (i > 255) ? 8'd255 : i[7:0]);
    step(284, 0, 0, 0, 0, 1, 0, 0, 0, 255);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
